wfg_drive_pat_fifo: RTL and testbench

Parametrised pattern driver for the waveform generator. It buffers AXI-stream pattern words in a DEPTH-entry FIFO and pops one word per pattern sync pulse. Each of CHANNELS output pins is driven from its bit of the current word, in one of four per-channel modes; one mode gates the bit to a begin/end subcycle window. It sits between the pattern-sync/subcycle generator and the chip pins, and adds underflow handling and frame-end signalling.

---
 rtl/wfg_drive_pat_fifo_if.sv | 26 ++
 rtl/wfg_drive_pat_fifo.sv | 141 ++++++++++++++
 tb/tb_wfg_drive_pat_fifo.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wfg_drive_pat_fifo_if.sv
// Pattern word stream between the pattern source and the pattern driver.
// Latency: none, wires only.
// Backpressure: the slave lowers tready while it cannot accept a word; the master holds the word.
// Signals: tvalid/tlast/tdata driven by master, tready driven by slave.
interface wfg_drive_pat_fifo_if #(
    parameter int unsigned AXIS_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [AXIS_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/wfg_drive_pat_fifo.sv
// Pattern driver: buffers stream words, pops one per sync, drives per-channel pins in 4 modes.
// Latency: sync in cycle t -> cur word in t+1 -> pins in t+2; config/subcycle -> pins 1 cycle.
// Backpressure: tready low while the FIFO holds DEPTH words; sync on empty flags underflow.
// Ports: clk/rst_n; pat_sync_i + pat_subcycle_cnt_i from the sync generator; ctrl_en/patsel/
//        cfg_begin/cfg_end/cfg_hold config; clr_underflow_i; axis_s stream slave;
//        pat_dout_o/pat_dout_en_o pins; fifo_level_o, underflow_o, frame_end_o status.
module wfg_drive_pat_fifo #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pat_sync_i,
    input  logic [7:0]                    pat_subcycle_cnt_i,
    input  logic [CHANNELS-1:0]           ctrl_en_q_i,
    input  logic [2*CHANNELS-1:0]         patsel_q_i,
    input  logic [7:0]                    cfg_begin_q_i,
    input  logic [7:0]                    cfg_end_q_i,
    input  logic                          cfg_hold_q_i,
    input  logic                          clr_underflow_i,
    wfg_drive_pat_fifo_if.slave           axis_s,
    output logic [CHANNELS-1:0]           pat_dout_o,
    output logic [CHANNELS-1:0]           pat_dout_en_o,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level_o,
    output logic                          underflow_o,
    output logic                          frame_end_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    // Entry layout: bit CHANNELS is tlast, low bits are the pattern word.
    logic [CHANNELS:0]   mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CHANNELS-1:0] cur_q, cur_d;
    logic                last_q, last_d;
    logic                popped_q;
    logic                underflow_q, underflow_d;
    logic [CHANNELS-1:0] dout_q, dout_d;

    logic                push;
    logic                pop;
    logic                underrun;
    logic                win;
    logic [CHANNELS:0]   head;

    assign axis_s.tready = (level_q != LW'(DEPTH));
    assign push          = axis_s.tvalid && axis_s.tready;
    assign pop           = pat_sync_i && (level_q != '0);
    assign underrun      = pat_sync_i && (level_q == '0);
    assign head          = mem_q[rd_ptr_q];

    // Window is half-open and never wraps, so begin >= end yields an empty window.
    assign win = (cfg_begin_q_i <= pat_subcycle_cnt_i) && (pat_subcycle_cnt_i < cfg_end_q_i);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cur_d       = cur_q;
        last_d      = last_q;
        underflow_d = underflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            cur_d    = head[CHANNELS-1:0];
            last_d   = head[CHANNELS];
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        if (underrun && !cfg_hold_q_i) begin
            cur_d = '0;
        end

        // A fresh underrun takes priority over the clear request.
        if (underrun) begin
            underflow_d = 1'b1;
        end else if (clr_underflow_i) begin
            underflow_d = 1'b0;
        end
    end

    always_comb begin
        dout_d = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (ctrl_en_q_i[k]) begin
                unique case (patsel_q_i[2*k +: 2])
                    2'b00:   dout_d[k] = 1'b0;
                    2'b01:   dout_d[k] = 1'b1;
                    2'b10:   dout_d[k] = cur_q[k];
                    default: dout_d[k] = cur_q[k] && win;
                endcase
            end
        end
    end

    // Storage is left unreset: pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {axis_s.tlast, axis_s.tdata[CHANNELS-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cur_q       <= '0;
            last_q      <= 1'b0;
            popped_q    <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            popped_q    <= pop;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    // last_q persists until the next pop; qualifying with popped_q makes a single-cycle pulse.
    assign frame_end_o   = popped_q && last_q;
    assign pat_dout_o    = dout_q;
    assign pat_dout_en_o = ctrl_en_q_i;
    assign fifo_level_o  = level_q;
    assign underflow_o   = underflow_q;
endmodule

// File: tb/tb_wfg_drive_pat_fifo.sv
// Bench for wfg_drive_pat_fifo: FIFO model plus output-word scoreboard, direct status checks.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stream pushes wait on tready with a bounded cycle budget.
module tb_wfg_drive_pat_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pat_sync_i = 1'b0;
    logic [7:0]  pat_subcycle_cnt_i = 8'd0;
    logic [7:0]  ctrl_en_q_i = 8'hFF;
    logic [15:0] patsel_q_i = 16'hAAAA;
    logic [7:0]  cfg_begin_q_i = 8'd0;
    logic [7:0]  cfg_end_q_i = 8'd0;
    logic        cfg_hold_q_i = 1'b1;
    logic        clr_underflow_i = 1'b0;
    logic [7:0]  pat_dout_o;
    logic [7:0]  pat_dout_en_o;
    logic [2:0]  fifo_level_o;
    logic        underflow_o;
    logic        frame_end_o;

    int checks = 0;
    int errors = 0;

    logic [8:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cur_m = 8'h00;

    wfg_drive_pat_fifo_if #(.AXIS_WIDTH(32)) axis_if ();

    wfg_drive_pat_fifo #(.CHANNELS(8), .AXIS_WIDTH(32), .DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pat_sync_i         (pat_sync_i),
        .pat_subcycle_cnt_i (pat_subcycle_cnt_i),
        .ctrl_en_q_i        (ctrl_en_q_i),
        .patsel_q_i         (patsel_q_i),
        .cfg_begin_q_i      (cfg_begin_q_i),
        .cfg_end_q_i        (cfg_end_q_i),
        .cfg_hold_q_i       (cfg_hold_q_i),
        .clr_underflow_i    (clr_underflow_i),
        .axis_s             (axis_if),
        .pat_dout_o         (pat_dout_o),
        .pat_dout_en_o      (pat_dout_en_o),
        .fifo_level_o       (fifo_level_o),
        .underflow_o        (underflow_o),
        .frame_end_o        (frame_end_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] f_model(input logic [7:0] w, input logic [7:0] en,
                                           input logic [15:0] ps, input logic [7:0] b,
                                           input logic [7:0] e, input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            case (ps[2*k +: 2])
                2'b00: r[k] = 1'b0;
                2'b01: r[k] = 1'b1;
                2'b10: r[k] = w[k];
                default: r[k] = w[k] && (b <= c) && (c < e);
            endcase
            if (!en[k]) r[k] = 1'b0;
        end
        return r;
    endfunction

    // Model the pop/underflow side of a sync edge and queue the word the pins must show.
    task automatic model_sync(output logic fe);
        logic [8:0] e;
        fe = 1'b0;
        if (mdl_q.size() > 0) begin
            e     = mdl_q.pop_front();
            cur_m = e[7:0];
            fe    = e[8];
        end else if (!cfg_hold_q_i) begin
            cur_m = 8'h00;
        end
        exp_q.push_back(cur_m);
    endtask

    task automatic sb_check();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got=none exp=word");
        end else begin
            chk("dout_word", pat_dout_o, exp_q.pop_front());
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = {24'h0, d};
        axis_if.tlast  = last;
        while (!axis_if.tready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready_timeout", axis_if.tready, 1'b1);
        tick();
        mdl_q.push_back({last, d});
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    task automatic do_sync();
        logic fe;
        pat_sync_i = 1'b1;
        model_sync(fe);
        tick();
        pat_sync_i = 1'b0;
        chk("frame_end", frame_end_o, fe);
        tick();
        chk("frame_end_pulse", frame_end_o, 1'b0);
        sb_check();
    endtask

    initial begin
        logic fe;
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        axis_if.tdata  = '0;

        #12;
        chk("rst_dout", pat_dout_o, 8'h00);
        chk("rst_level", fifo_level_o, 3'd0);
        chk("rst_tready", axis_if.tready, 1'b1);
        chk("rst_underflow", underflow_o, 1'b0);
        chk("rst_frame_end", frame_end_o, 1'b0);
        chk("dout_en", pat_dout_en_o, 8'hFF);
        #10 rst_n = 1'b1;
        tick();

        // Basic NRZ: three words, sync every 16 cycles.
        push_word(8'h01, 1'b0);
        push_word(8'h02, 1'b0);
        push_word(8'h03, 1'b0);
        chk("level_3", fifo_level_o, 3'd3);
        for (int i = 0; i < 3; i++) begin
            do_sync();
            chk("level_drain", fifo_level_o, 3'(2 - i));
            repeat (14) tick();
        end

        // Full FIFO with a held fifth word.
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i), 1'b0);
        chk("full_level", fifo_level_o, 3'd4);
        chk("full_tready", axis_if.tready, 1'b0);
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = 32'h14;
        tick();
        tick();
        chk("full_hold_level", fifo_level_o, 3'd4);
        chk("full_hold_tready", axis_if.tready, 1'b0);
        pat_sync_i = 1'b1;
        model_sync(fe);
        tick();
        pat_sync_i = 1'b0;
        chk("pop_level", fifo_level_o, 3'd3);
        chk("pop_tready", axis_if.tready, 1'b1);
        tick();
        axis_if.tvalid = 1'b0;
        mdl_q.push_back({1'b0, 8'h14});
        chk("fifth_level", fifo_level_o, 3'd4);
        sb_check();
        for (int i = 0; i < 4; i++) do_sync();
        chk("drained_level", fifo_level_o, 3'd0);

        // Underflow handling.
        push_word(8'hA5, 1'b0);
        do_sync();
        cfg_hold_q_i = 1'b1;
        do_sync();
        chk("uf_hold_flag", underflow_o, 1'b1);
        clr_underflow_i = 1'b1;
        tick();
        clr_underflow_i = 1'b0;
        chk("uf_clear", underflow_o, 1'b0);
        cfg_hold_q_i = 1'b0;
        do_sync();
        chk("uf_zero_flag", underflow_o, 1'b1);
        clr_underflow_i = 1'b1;
        pat_sync_i = 1'b1;
        model_sync(fe);
        tick();
        clr_underflow_i = 1'b0;
        pat_sync_i = 1'b0;
        chk("uf_clr_vs_new", underflow_o, 1'b1);
        tick();
        sb_check();
        clr_underflow_i = 1'b1;
        tick();
        clr_underflow_i = 1'b0;
        chk("uf_clear2", underflow_o, 1'b0);
        cfg_hold_q_i = 1'b1;

        // RZ window sweep, then empty window, then mixed modes and enables.
        push_word(8'hFF, 1'b0);
        do_sync();
        patsel_q_i    = 16'hFFFF;
        cfg_begin_q_i = 8'd3;
        cfg_end_q_i   = 8'd6;
        for (int c = 0; c < 10; c++) begin
            pat_subcycle_cnt_i = 8'(c);
            tick();
            chk("rz_win", pat_dout_o, (c >= 3 && c < 6) ? 8'hFF : 8'h00);
        end
        cfg_begin_q_i = 8'd6;
        cfg_end_q_i   = 8'd3;
        for (int c = 0; c < 10; c++) begin
            pat_subcycle_cnt_i = 8'(c);
            tick();
            chk("rz_empty", pat_dout_o, 8'h00);
        end
        ctrl_en_q_i   = 8'h5A;
        patsel_q_i    = 16'b11_10_01_00_11_10_01_00;
        cfg_begin_q_i = 8'd0;
        cfg_end_q_i   = 8'd4;
        chk("dout_en_mix", pat_dout_en_o, 8'h5A);
        pat_subcycle_cnt_i = 8'd2;
        tick();
        chk("mix_in", pat_dout_o, f_model(cur_m, 8'h5A, 16'b11_10_01_00_11_10_01_00, 8'd0, 8'd4, 8'd2));
        ctrl_en_q_i = 8'hF0;
        pat_subcycle_cnt_i = 8'd7;
        tick();
        chk("mix_out", pat_dout_o, f_model(cur_m, 8'hF0, 16'b11_10_01_00_11_10_01_00, 8'd0, 8'd4, 8'd7));
        ctrl_en_q_i = 8'hFF;
        patsel_q_i  = 16'hAAAA;
        pat_subcycle_cnt_i = 8'd0;
        tick();

        // Frame end on the third pop only.
        push_word(8'h31, 1'b0);
        push_word(8'h32, 1'b0);
        push_word(8'h33, 1'b1);
        for (int i = 0; i < 3; i++) do_sync();

        // Push and pop together at level 2.
        push_word(8'h61, 1'b0);
        push_word(8'h62, 1'b0);
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = 32'h63;
        pat_sync_i = 1'b1;
        model_sync(fe);
        mdl_q.push_back({1'b0, 8'h63});
        tick();
        axis_if.tvalid = 1'b0;
        pat_sync_i = 1'b0;
        chk("same_cycle_level", fifo_level_o, 3'd2);
        tick();
        sb_check();
        do_sync();
        do_sync();

        // Asynchronous reset with data in flight.
        push_word(8'h77, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", fifo_level_o, 3'd0);
        chk("arst_dout", pat_dout_o, 8'h00);
        chk("arst_tready", axis_if.tready, 1'b1);
        mdl_q.delete();
        cur_m = 8'h00;
        #3 rst_n = 1'b1;
        tick();
        do_sync();
        chk("arst_uf", underflow_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
